rns_recon_arbiter: RTL and testbench

Shares one pipelined RNS-to-integer (CRT) reconstruction engine among `N_REQ` requesters. Each requester presents a packed 4-residue RNS word; the block arbitrates, converts at one word per cycle, and returns the signed 32-bit integer tagged with the requester index. It sits between the RNS compute lanes and the integer write-back path, and replaces per-lane instances of the combinational reconstruction logic, which is too large and too slow to replicate.

---
 rtl/rns_recon_arbiter_pkg.sv | 49 ++++
 rtl/rns_crt_pipe.sv | 94 +++++++++
 rtl/rns_recon_arbiter.sv | 105 ++++++++++
 tb/tb_rns_recon_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rns_recon_arbiter_pkg.sv
// Shared RNS constants, the packed residue word and a range-check helper.
package rns_recon_arbiter_pkg;

  // Channel moduli and their product.
  localparam logic [7:0]  RNS_M0 = 8'd251;
  localparam logic [7:0]  RNS_M1 = 8'd241;
  localparam logic [7:0]  RNS_M2 = 8'd239;
  localparam logic [7:0]  RNS_M3 = 8'd233;
  localparam logic [31:0] RNS_M  = 32'd3368562317;

  // CRT basis constants. The list runs opposite to the moduli: A0 is the
  // basis of M3 (1 mod 233, 0 mod the others), A3 is the basis of M0.
  localparam logic [31:0] RNS_A0 = 32'd3021585941;
  localparam logic [31:0] RNS_A1 = 32'd1099363434;
  localparam logic [31:0] RNS_A2 = 32'd1663315003;
  localparam logic [31:0] RNS_A3 = 32'd952860257;

  // Residues at or above the midpoint encode negative numbers.
  localparam logic [31:0] RNS_MIDDLE_POINT = 32'd1684281159;
  localparam logic [31:0] INT_RNS_DELTA    = 32'd926404979;

  localparam int PROD_W = 46;
  localparam int SUM_W  = 48;

  // r0 sits in [7:0], r3 in [31:24].
  typedef struct packed {
    logic [7:0] r3;
    logic [7:0] r2;
    logic [7:0] r1;
    logic [7:0] r0;
  } rns_word_t;

  // Basis constant that multiplies the residue of modulus index idx.
  function automatic logic [31:0] crt_basis(input int unsigned idx);
    case (idx)
      0:       return RNS_A3;
      1:       return RNS_A2;
      2:       return RNS_A1;
      default: return RNS_A0;
    endcase
  endfunction

  // True when any residue is not reduced below its modulus.
  function automatic logic rns_word_err(input rns_word_t w);
    return (w.r0 >= RNS_M0) || (w.r1 >= RNS_M1) ||
           (w.r2 >= RNS_M2) || (w.r3 >= RNS_M3);
  endfunction

endpackage

// File: rtl/rns_crt_pipe.sv
// Three-stage CRT reconstruction datapath: weighted products, sum, then
// reduction mod M with the signed map. Every stage carries valid/id/err and
// the whole pipe freezes while stall is high.
module rns_crt_pipe
  import rns_recon_arbiter_pkg::*;
#(
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  input  rns_word_t       in_word,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  output logic            out_err,
  output logic [31:0]     out_int
);

  logic              s1_valid;
  logic [ID_W-1:0]   s1_id;
  logic              s1_err;
  logic [PROD_W-1:0] s1_p0, s1_p1, s1_p2, s1_p3;

  logic              s2_valid;
  logic [ID_W-1:0]   s2_id;
  logic              s2_err;
  logic [SUM_W-1:0]  s2_sum;

  logic [31:0]       s2_mod;
  logic [31:0]       s2_signed;

  // S1: multiply each residue by its basis constant and flag bad residues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_err   <= 1'b0;
      s1_p0    <= '0;
      s1_p1    <= '0;
      s1_p2    <= '0;
      s1_p3    <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_id    <= in_id;
      s1_err   <= rns_word_err(in_word);
      s1_p0    <= PROD_W'(in_word.r0) * PROD_W'(crt_basis(0));
      s1_p1    <= PROD_W'(in_word.r1) * PROD_W'(crt_basis(1));
      s1_p2    <= PROD_W'(in_word.r2) * PROD_W'(crt_basis(2));
      s1_p3    <= PROD_W'(in_word.r3) * PROD_W'(crt_basis(3));
    end
  end

  // S2: accumulate the four weighted products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_err   <= 1'b0;
      s2_sum   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_err   <= s1_err;
      s2_sum   <= SUM_W'(s1_p0) + SUM_W'(s1_p1) + SUM_W'(s1_p2) + SUM_W'(s1_p3);
    end
  end

  // Reduce mod M; adding DELTA wraps upper-half values to their negative form.
  always_comb begin
    s2_mod    = 32'(s2_sum % SUM_W'(RNS_M));
    s2_signed = s2_mod;
    if (s2_mod >= RNS_MIDDLE_POINT) begin
      s2_signed = s2_mod + INT_RNS_DELTA;
    end
  end

  // S3: output register, held while downstream backpressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_err   <= 1'b0;
      out_int   <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      out_id    <= s2_id;
      out_err   <= s2_err;
      out_int   <= s2_signed;
    end
  end

endmodule

// File: rtl/rns_recon_arbiter.sv
// Arbitrates N_REQ requesters onto one shared CRT reconstruction pipe.
// Define RNS_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the
// lowest valid index always wins and no pointer register exists.
module rns_recon_arbiter
  import rns_recon_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*32-1:0]      req_rns,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_int,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic                     resp_err
);

  localparam int ID_W = $clog2(N_REQ);

  logic            stall;
  logic            accept;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  rns_word_t       grant_word;

  assign stall  = resp_valid && !resp_ready;
  assign accept = rst_n && !stall && grant_valid;

`ifdef RNS_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cand;

  // Search from the pointer upward, wrapping; first valid requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_valid && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Pointer moves past the grantee only when a request actually transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest valid index granted.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
  end
`endif

  // Route the granted requester's residue word into the pipe.
  always_comb begin
    grant_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_word = req_rns[i*32 +: 32];
      end
    end
  end

  // One-hot accept, suppressed during stall and reset.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  rns_crt_pipe #(
    .ID_W(ID_W)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .in_valid (accept),
    .in_id    (grant_id),
    .in_word  (grant_word),
    .out_valid(resp_valid),
    .out_id   (resp_id),
    .out_err  (resp_err),
    .out_int  (resp_int)
  );

endmodule

// File: tb/tb_rns_recon_arbiter.sv
// Randomized scoreboard bench for rns_recon_arbiter. Legal words are built
// from a chosen integer, so the expected result is that integer; words with
// out-of-range residues are predicted with a plain CRT computation.
module tb_rns_recon_arbiter;

  localparam int     N_REQ = 4;
  localparam int     ID_W  = 2;
  localparam longint MOD_PRODUCT = longint'(251) * 241 * 239 * 233;
  localparam longint MAX_POS = (MOD_PRODUCT - 1) / 2;

  int mods [4] = '{251, 241, 239, 233};

  typedef struct packed {
    logic [31:0] rns;
    logic [31:0] value;
    logic        err;
  } word_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     value;
    logic            err;
  } resp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*32-1:0]  req_rns;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_int;
  logic [ID_W-1:0]      resp_id;
  logic                 resp_err;

  word_t req_q [N_REQ][$];
  resp_t sb_q [$];
  bit    pipe_m [$];
  int    ptr_m;
  int    checks_total  = 0;
  int    checks_passed = 0;

  rns_recon_arbiter #(
    .N_REQ(N_REQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rns   (req_rns),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_int  (resp_int),
    .resp_id   (resp_id),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Residues of an integer, packed r0 in the low byte.
  function automatic logic [31:0] to_rns(input longint x);
    logic [31:0] w;
    longint r;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      r = x % mods[i];
      if (r < 0) r = r + mods[i];
      w[i*8 +: 8] = 8'(r);
    end
    return w;
  endfunction

  // Chinese remainder reconstruction with basis inverses found by search,
  // then the symmetric signed interpretation of the result.
  function automatic logic [31:0] crt_ref(input logic [31:0] w);
    longint t, ni, inv;
    t = 0;
    for (int i = 0; i < 4; i++) begin
      ni  = MOD_PRODUCT / mods[i];
      inv = 0;
      for (int k = 1; k < mods[i]; k++) begin
        if (((ni % mods[i]) * k) % mods[i] == 1) inv = k;
      end
      t = (t + ((longint'(w[i*8 +: 8]) * ni) % MOD_PRODUCT) * inv) % MOD_PRODUCT;
    end
    if (t > MAX_POS) t = t - MOD_PRODUCT;
    return 32'(t);
  endfunction

  function automatic word_t make_legal(input longint x);
    word_t w;
    w.rns   = to_rns(x);
    w.value = 32'(x);
    w.err   = 1'b0;
    return w;
  endfunction

  function automatic word_t make_raw(input logic [31:0] rns);
    word_t w;
    w.rns   = rns;
    w.value = crt_ref(rns);
    w.err   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (int'(rns[i*8 +: 8]) >= mods[i]) w.err = 1'b1;
    end
    return w;
  endfunction

  function automatic word_t gen_legal();
    longint x;
    x = longint'($urandom_range(32'd3368562316, 0)) - MAX_POS;
    return make_legal(x);
  endfunction

  function automatic word_t gen_err();
    logic [31:0] w;
    int j;
    w = $urandom;
    j = $urandom_range(3, 0);
    w[j*8 +: 8] = 8'($urandom_range(255, mods[j]));
    return make_raw(w);
  endfunction

  function automatic bit busy();
    bit b;
    b = (sb_q.size() != 0);
    for (int i = 0; i < N_REQ; i++) if (req_q[i].size() != 0) b = 1'b1;
    foreach (pipe_m[i]) if (pipe_m[i]) b = 1'b1;
    return b;
  endfunction

  // One cycle: present pending words, predict grant and output presence,
  // then advance the model as the coming clock edge will.
  task automatic apply_stimulus(input bit rdy);
    bit stall_m;
    int g;
    int c;
    @(negedge clk);
    resp_ready = rdy;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_q[i].size() != 0) begin
        req_valid[i] = 1'b1;
        req_rns[i*32 +: 32] = req_q[i][0].rns;
      end else begin
        req_valid[i] = 1'b0;
        req_rns[i*32 +: 32] = $urandom;
      end
    end
    #2;
    stall_m = pipe_m[0] && !rdy;
    g = -1;
    if (!stall_m) begin
      for (int k = 0; k < N_REQ; k++) begin
`ifdef RNS_ARB_ROUND_ROBIN_EN
        c = (ptr_m + k) % N_REQ;
`else
        c = k;
`endif
        if (g < 0 && req_q[c].size() != 0) g = c;
      end
    end
    check_output("resp_valid", 64'(resp_valid), 64'(pipe_m[0]));
    check_output("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    if (!stall_m) begin
      void'(pipe_m.pop_front());
      pipe_m.push_back(g >= 0);
    end
    if (g >= 0) begin
      sb_q.push_back('{id: ID_W'(g), value: req_q[g][0].value, err: req_q[g][0].err});
      void'(req_q[g].pop_front());
      ptr_m = (g + 1) % N_REQ;
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (busy() && n < max_cycles) begin
      apply_stimulus(1'b1);
      n++;
    end
    check_output("drain_idle", 64'(busy()), 64'd0);
  endtask

  // Hold reset with every requester asserting valid; nothing may be granted.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n      = 1'b0;
    req_valid  = '1;
    req_rns    = {$urandom, $urandom, $urandom, $urandom};
    resp_ready = 1'b1;
    #2;
    check_output("rst_req_ready", 64'(req_ready), 64'd0);
    check_output("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_output("rst_resp_int", 64'(resp_int), 64'd0);
    check_output("rst_resp_id", 64'(resp_id), 64'd0);
    check_output("rst_resp_err", 64'(resp_err), 64'd0);
    sb_q.delete();
    pipe_m = '{1'b0, 1'b0, 1'b0};
    ptr_m  = 0;
    repeat (cycles) @(negedge clk);
    check_output("rst_hold_ready", 64'(req_ready), 64'd0);
    check_output("rst_hold_valid", 64'(resp_valid), 64'd0);
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  // Monitor: every presented response must match the oldest expected one
  // (and stay matched while stalled); it retires when accepted downstream.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && resp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          check_output("resp_int", 64'(resp_int), 64'(sb_q[0].value));
          check_output("resp_id", 64'(resp_id), 64'(sb_q[0].id));
          check_output("resp_err", 64'(resp_err), 64'(sb_q[0].err));
          if (resp_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_rns    = '0;
    resp_ready = 1'b0;
    pipe_m     = '{1'b0, 1'b0, 1'b0};
    ptr_m      = 0;

    do_reset(2);

    // Identity, minus one, zero and the two extremes of the signed range.
    req_q[0].push_back('{rns: 32'h01010101, value: 32'd1, err: 1'b0});
    drain(50);
    req_q[2].push_back('{rns: 32'hE8EEF0FA, value: 32'hFFFFFFFF, err: 1'b0});
    req_q[2].push_back('{rns: 32'h00000000, value: 32'h00000000, err: 1'b0});
    drain(50);
    req_q[1].push_back(make_legal(MAX_POS));
    req_q[1].push_back(make_legal(-MAX_POS));
    drain(50);

    // Out-of-range residues still produce a flagged result.
    req_q[1].push_back(make_raw(32'h000000FB));
    req_q[3].push_back(make_raw(32'hE9000000));
    drain(50);

    // All requesters loaded at once: grant order follows the policy.
    for (int i = 0; i < N_REQ; i++) begin
      repeat (6) req_q[i].push_back(gen_legal());
    end
    drain(100);

    // Five-word stream with downstream blocked for four cycles mid-stream.
    repeat (5) req_q[3].push_back(gen_legal());
    for (int c = 0; c < 12; c++) apply_stimulus(!(c >= 4 && c < 8));
    drain(50);

    // Randomized traffic and backpressure.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(9, 0) < 4) begin
        int r;
        r = $urandom_range(N_REQ - 1, 0);
        if (req_q[r].size() < 4) begin
          if ($urandom_range(4, 0) == 0) req_q[r].push_back(gen_err());
          else req_q[r].push_back(gen_legal());
        end
      end
      apply_stimulus($urandom_range(3, 0) != 0);
    end
    drain(200);

    // Reset with three words in flight: they vanish, next grant is 0.
    req_q[0].push_back(gen_legal());
    req_q[1].push_back(gen_legal());
    req_q[2].push_back(gen_legal());
    repeat (3) apply_stimulus(1'b1);
    do_reset(2);
    for (int i = 0; i < N_REQ; i++) req_q[i].push_back(gen_legal());
    drain(50);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
